// File: rtl/l1_pkg.sv
// Shared encodings for the L1 I/D-cache to MMU arbiter: owner codes, FSM states, defaults.
package l1_pkg;

  localparam int L1_LINE_W = 256;
  localparam int L1_ADDR_W = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // Encoding of the last-served side used by the round-robin picker.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_REL   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/l1_rr_pick.sv
// Combinational 2-way round-robin picker. A pending D read after a D writeback
// (lock_d) always wins so the refill follows its own writeback.
module l1_rr_pick
  import l1_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last,
  input  logic       lock_d,
  output logic [1:0] grant
);

  always_comb begin
    grant = OWN_NONE;
    if (lock_d) begin
      grant = OWN_D;
    end else if (req_i && req_d) begin
      grant = (last == LAST_I) ? OWN_D : OWN_I;
    end else if (req_i) begin
      grant = OWN_I;
    end else if (req_d) begin
      grant = OWN_D;
    end
  end

endmodule

// File: rtl/l1_mmu_arbiter.sv
// Shares the MMU line-transfer port between the L1 I-cache and D-cache with
// round-robin grants, a writeback-then-refill lock and a sticky watchdog.
module l1_mmu_arbiter
  import l1_pkg::*;
#(
  parameter int          LINE_W  = L1_LINE_W,
  parameter int          ADDR_W  = L1_ADDR_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ic_req_read,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_req_read,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic [1:0]        owner,
  output logic              timeout
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              last;
  logic              lock;
  logic [1:0]        grant;
  logic              granted;
  logic [WD_W-1:0]   wdog;
  logic [WD_W-1:0]   wdog_inc;
  logic [WD_W-1:0]   wdog_max;

  l1_rr_pick u_pick (
    .req_i  (ic_req_read),
    .req_d  (dc_req_read | dc_req_write),
    .last   (last),
    .lock_d (lock & dc_req_read),
    .grant  (grant)
  );

  assign granted = (state == ST_GNT_I) || (state == ST_GNT_D);

  always_comb begin
    state_next     = state;
    owner          = OWN_NONE;
    mmu_req_read   = 1'b0;
    mmu_req_write  = 1'b0;
    mmu_req_addr   = '0;
    mmu_write_data = '0;
    ic_done        = 1'b0;
    ic_read_data   = '0;
    dc_done        = 1'b0;
    dc_read_data   = '0;
    case (state)
      ST_IDLE: begin
        if (grant == OWN_I) begin
          state_next = ST_GNT_I;
        end else if (grant == OWN_D) begin
          state_next = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        owner        = OWN_I;
        mmu_req_read = ic_req_read;
        mmu_req_addr = ic_req_addr;
        if (mmu_done) begin
          ic_done      = 1'b1;
          ic_read_data = mmu_read_data;
          state_next   = ST_REL;
        end
      end
      ST_GNT_D: begin
        // A writeback wins over a simultaneous refill from the same cache.
        owner          = OWN_D;
        mmu_req_write  = dc_req_write;
        mmu_req_read   = dc_req_read & ~dc_req_write;
        mmu_req_addr   = dc_req_addr;
        mmu_write_data = dc_write_data;
        if (mmu_done) begin
          dc_done      = 1'b1;
          dc_read_data = mmu_read_data;
          state_next   = ST_REL;
        end
      end
      ST_REL: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= LAST_I;
      lock <= 1'b0;
    end else if (granted && mmu_done) begin
      last <= (state == ST_GNT_D) ? LAST_D : LAST_I;
      lock <= (state == ST_GNT_D) && dc_req_write;
    end
  end

  assign wdog_max = WD_W'(TIMEOUT);
  assign wdog_inc = (wdog == wdog_max) ? wdog : wdog + 1'b1;

  // The watchdog only flags a stuck transfer; it never releases the grant.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else if ((state == ST_IDLE) && (grant != OWN_NONE)) begin
      wdog <= '0;
    end else if (granted) begin
      wdog <= wdog_inc;
      if (wdog_inc == wdog_max) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Randomized bench for l1_mmu_arbiter against a transaction-level port model,
// with a done-event scoreboard and per-cycle output checks.
module tb_l1_mmu_arbiter;
  import l1_pkg::*;

  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic              sys_clk;
  logic              rst_n;
  logic              ic_req_read;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_done;
  logic [LINE_W-1:0] ic_read_data;
  logic              dc_req_read;
  logic              dc_req_write;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_write_data;
  logic              dc_done;
  logic [LINE_W-1:0] dc_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic [1:0]        owner;
  logic              timeout;

  l1_mmu_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr),
    .ic_done(ic_done), .ic_read_data(ic_read_data),
    .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
    .dc_req_addr(dc_req_addr), .dc_write_data(dc_write_data),
    .dc_done(dc_done), .dc_read_data(dc_read_data),
    .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write),
    .mmu_req_addr(mmu_req_addr), .mmu_write_data(mmu_write_data),
    .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
    .owner(owner), .timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run did not finish");
    $fatal(1, "time limit");
  end

  // ---------------- model and bench state ----------------
  // m_port: 0 free, 1 I owns the port, 2 D owns the port, 3 release gap
  int                m_port;
  bit                m_last_d, m_lock, m_timeout;
  int                m_wd, lat, cnt, fixed_lat;
  bit                i_pend, d_pend, d_rd, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, rdata_drv;
  bit                done_drv;
  bit                rand_req, rand_stray, resp_en, lock_test, mon_en;

  logic [1:0]        e_owner;
  logic              e_rd, e_wr, e_ic_done, e_dc_done, e_timeout;
  logic [ADDR_W-1:0] e_addr;
  logic [LINE_W-1:0] e_wdata, e_ic_rd, e_dc_rd;

  logic [LINE_W+1:0] exp_q[$];
  int                n_cmp, n_bad;

  function automatic void check(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_port = 0; m_last_d = 1'b0; m_lock = 1'b0; m_timeout = 1'b0; m_wd = 0;
    i_pend = 1'b0; d_pend = 1'b0; d_rd = 1'b0; d_wr = 1'b0; done_drv = 1'b0;
    ic_req_read = 1'b0; ic_req_addr = '0; dc_req_read = 1'b0; dc_req_write = 1'b0;
    dc_req_addr = '0; dc_write_data = '0; mmu_done = 1'b0; mmu_read_data = '0;
    e_owner = OWN_NONE; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    e_ic_done = 1'b0; e_dc_done = 1'b0; e_ic_rd = '0; e_dc_rd = '0; e_timeout = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    int  completed;
    int  g;
    int  k;
    bit  ri, rq;
    completed = 0;
    @(posedge sys_clk); #1;
    // Advance the model across the edge using what was driven last cycle.
    if (m_port == 0) begin
      ri = ic_req_read;
      rq = dc_req_read || dc_req_write;
      g = 0;
      if (m_lock && dc_req_read) g = 2;
      else if (ri && rq) g = m_last_d ? 1 : 2;
      else if (ri) g = 1;
      else if (rq) g = 2;
      if (g != 0) begin
        m_port = g; m_wd = 0; cnt = 0;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
      end
    end else if (m_port == 1 || m_port == 2) begin
      if (m_wd < TIMEOUT) m_wd++;
      if (m_wd == TIMEOUT) m_timeout = 1'b1;
      if (mmu_done) begin
        m_last_d = (m_port == 2);
        m_lock = (m_port == 2) && dc_req_write;
        completed = m_port;
        m_port = 3;
      end
    end else begin
      m_port = 0;
    end
    // Requesters: drop a finished request; optionally issue new ones.
    if (completed == 1) i_pend = 1'b0;
    if (completed == 2) begin
      if (lock_test && d_wr) begin
        d_rd = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0340;
      end else begin
        d_pend = 1'b0;
      end
    end
    if (rand_req) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        d_pend = 1'b1; d_rd = (k != 1); d_wr = (k != 0);
        d_addr = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
      end
    end
    // MMU responder, including stray done pulses while nobody owns the port.
    done_drv = 1'b0;
    if (m_port == 1 || m_port == 2) begin
      if (resp_en) begin
        if (cnt == lat) done_drv = 1'b1;
        else cnt++;
      end
    end else if (rand_stray && $urandom_range(0, 5) == 0) begin
      done_drv = 1'b1;
    end
    rdata_drv = rand_line();
    ic_req_read   = i_pend;
    ic_req_addr   = i_addr;
    dc_req_read   = d_pend && d_rd;
    dc_req_write  = d_pend && d_wr;
    dc_req_addr   = d_addr;
    dc_write_data = d_wdata;
    mmu_done      = done_drv;
    mmu_read_data = rdata_drv;
    // Expected outputs for this cycle.
    e_owner = OWN_NONE; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    e_ic_done = 1'b0; e_dc_done = 1'b0; e_ic_rd = '0; e_dc_rd = '0;
    e_timeout = m_timeout;
    if (m_port == 1) begin
      e_owner = OWN_I; e_rd = 1'b1; e_addr = i_addr;
      if (done_drv) begin
        e_ic_done = 1'b1; e_ic_rd = rdata_drv;
        exp_q.push_back({2'd1, rdata_drv});
      end
    end else if (m_port == 2) begin
      e_owner = OWN_D; e_wr = d_wr; e_rd = d_rd && !d_wr; e_addr = d_addr; e_wdata = d_wdata;
      if (done_drv) begin
        e_dc_done = 1'b1; e_dc_rd = rdata_drv;
        exp_q.push_back({2'd2, rdata_drv});
      end
    end
  endtask

  task automatic run_until_idle(input string name, input int bound);
    int n;
    n = 0;
    while (!(m_port == 0 && !i_pend && !d_pend) && n < bound) begin
      step();
      n++;
    end
    step();
    check({"idle_", name}, LINE_W'(n < bound), LINE_W'(1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sys_clk) begin
    logic [LINE_W+1:0] got;
    if (mon_en) begin
      check("owner", LINE_W'(owner), LINE_W'(e_owner));
      check("mmu_req_read", LINE_W'(mmu_req_read), LINE_W'(e_rd));
      check("mmu_req_write", LINE_W'(mmu_req_write), LINE_W'(e_wr));
      check("mmu_req_addr", LINE_W'(mmu_req_addr), LINE_W'(e_addr));
      check("mmu_write_data", mmu_write_data, e_wdata);
      check("ic_done", LINE_W'(ic_done), LINE_W'(e_ic_done));
      check("dc_done", LINE_W'(dc_done), LINE_W'(e_dc_done));
      check("ic_read_data", ic_read_data, e_ic_rd);
      check("dc_read_data", dc_read_data, e_dc_rd);
      check("timeout", LINE_W'(timeout), LINE_W'(e_timeout));
      if (ic_done || dc_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got ic_done=%0b dc_done=%0b expected no done (t=%0t)",
                   ic_done, dc_done, $time);
        end else begin
          got = exp_q.pop_front();
          check("done_side", LINE_W'(ic_done ? 2'd1 : 2'd2), LINE_W'(got[LINE_W+1:LINE_W]));
          check("done_data", ic_done ? ic_read_data : dc_read_data, got[LINE_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0; mon_en = 1'b0;
    rand_req = 1'b0; rand_stray = 1'b0; resp_en = 1'b1; lock_test = 1'b0; fixed_lat = -1;
    i_addr = '0; d_addr = '0; d_wdata = '0; lat = 0; cnt = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_owner", LINE_W'(owner), LINE_W'(OWN_NONE));
    check("rst_mmu_req_read", LINE_W'(mmu_req_read), LINE_W'(0));
    check("rst_timeout", LINE_W'(timeout), LINE_W'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single I read, done on the 4th granted cycle.
    fixed_lat = 3;
    i_pend = 1'b1; i_addr = 32'h0000_1040;
    run_until_idle("single_i", 40);
    fixed_lat = -1;

    // Simultaneous I and D reads: D first because last is I.
    i_pend = 1'b1; i_addr = 32'h0000_0100;
    d_pend = 1'b1; d_rd = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0200; d_wdata = rand_line();
    run_until_idle("simul", 60);

    // Writeback then refill lock with I pending throughout.
    lock_test = 1'b1;
    i_pend = 1'b1; i_addr = 32'h0000_1040;
    d_pend = 1'b1; d_rd = 1'b0; d_wr = 1'b1; d_addr = 32'h0000_0300; d_wdata = rand_line();
    run_until_idle("lock", 80);
    lock_test = 1'b0;

    // D read and write together: write wins.
    d_pend = 1'b1; d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0500; d_wdata = rand_line();
    run_until_idle("rd_wr", 40);

    // Random traffic with stray MMU done pulses.
    rand_req = 1'b1; rand_stray = 1'b1;
    repeat (800) step();
    rand_req = 1'b0; rand_stray = 1'b0;
    run_until_idle("drain", 100);

    // Stuck D writeback: watchdog fires and stays set, grant held.
    resp_en = 1'b0;
    d_pend = 1'b1; d_rd = 1'b0; d_wr = 1'b1; d_addr = 32'h0000_0700; d_wdata = rand_line();
    repeat (14) step();
    check("timeout_set", LINE_W'(timeout), LINE_W'(1));
    check("grant_held", LINE_W'(owner), LINE_W'(OWN_D));

    // Asynchronous reset in the middle of the grant.
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_owner", LINE_W'(owner), LINE_W'(OWN_NONE));
    check("arst_mmu_req_write", LINE_W'(mmu_req_write), LINE_W'(0));
    check("arst_mmu_req_addr", LINE_W'(mmu_req_addr), LINE_W'(0));
    check("arst_timeout", LINE_W'(timeout), LINE_W'(0));
    model_reset();
    resp_en = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    i_pend = 1'b1; i_addr = 32'h0000_0900;
    run_until_idle("post_reset", 40);

    check("exp_q_empty", LINE_W'(exp_q.size()), LINE_W'(0));
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l1_mmu_arbiter.md
Name: l1_mmu_arbiter

Overview:
- Shares the single MMU line-transfer port between the L1 instruction cache and the L1 data cache.
- Grants one requester at a time and forwards that requester's request, address and write data to the MMU.
- Routes the MMU done pulse and read data back to the owner only.
- Uses round-robin fairness, a D-cache writeback-then-refill lock, and a per-transaction watchdog counter.

Parameters:
- LINE_W, 256, cache line width in bits.
- ADDR_W, 32, address width.
- TIMEOUT, 1023, cycles a grant may stay outstanding before `timeout` asserts.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- ic_req_read  in  1  I-cache line read request (level, held until done).
- ic_req_addr  in  ADDR_W  I-cache request address.
- ic_done  out  1  one-cycle done pulse to the I-cache.
- ic_read_data  out  LINE_W  line returned to the I-cache.
- dc_req_read  in  1  D-cache line read request.
- dc_req_write  in  1  D-cache line write (writeback) request.
- dc_req_addr  in  ADDR_W  D-cache request address.
- dc_write_data  in  LINE_W  D-cache writeback data.
- dc_done  out  1  one-cycle done pulse to the D-cache.
- dc_read_data  out  LINE_W  line returned to the D-cache.
- mmu_req_read  out  1  read request to the MMU.
- mmu_req_write  out  1  write request to the MMU.
- mmu_req_addr  out  ADDR_W  address to the MMU.
- mmu_write_data  out  LINE_W  write data to the MMU.
- mmu_done  in  1  MMU transfer complete, one-cycle pulse.
- mmu_read_data  in  LINE_W  MMU read data, valid while mmu_done is high.
- owner  out  2  current grant: 0 none, 1 I-cache, 2 D-cache.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, last=I, lock=0, wdog=0, timeout=0.
  - All mmu_req_*, ic_done and dc_done are 0; owner=0.
- States: IDLE, GNT_I, GNT_D, REL. All transitions occur on the posedge of sys_clk.
- IDLE:
  - Only one requester active (I = ic_req_read; D = dc_req_read|dc_req_write): grant it.
  - Both active: grant the side not equal to `last`.
  - If lock=1 and dc_req_read=1: grant D regardless of `last`.
  - A grant takes effect on the next cycle.
- GNT_I / GNT_D:
  - mmu_req_* are driven combinationally from the owner's inputs; the other side is ignored.
  - D-cache with both read and write high: write has priority; mmu_req_read is masked.
  - On mmu_done:
    - Owner's done is 1 in the same cycle.
    - Owner's read_data = mmu_read_data in the same cycle.
    - last <= owner; next state REL.
    - lock <= 1 only if the completed transfer was a D write; otherwise lock <= 0.
  - If the owner drops its request before done: hold the grant anyway. The MMU transaction is not abortable.
- REL:
  - Lasts exactly one cycle. mmu_req_* = 0.
  - Gives the registered requesters a cycle to deassert; then returns to IDLE.
  - Minimum spacing between consecutive MMU requests is therefore 2 cycles.
- Outside a granted done cycle: ic_done=0, dc_done=0, and both read_data outputs = 0.
- mmu_done while in IDLE or REL: ignored; it produces no done pulse.
- Watchdog:
  - wdog clears on entry to GNT_* and increments each granted cycle, saturating at TIMEOUT.
  - When wdog reaches TIMEOUT, timeout <= 1. It stays set until reset. The grant is not released.
- Request latency: request seen in IDLE -> MMU request visible 1 cycle later.

Decomposition:
- Shared package (l1_pkg): owner encoding constants (OWN_NONE/OWN_I/OWN_D), state encodings, LINE_W default.
- One sub-module: l1_rr_pick, a combinational 2-way round-robin picker (inputs req_i, req_d, last, lock_d; output grant).
- FSM, lock and watchdog stay in the top module.

Test Plan:
- Single I request: ic_req_read=1, addr 0x0000_1040; mmu_done on cycle 4 with data 0xA5.. -> mmu_req_read=1 and mmu_req_addr=0x0000_1040 from cycle 1; ic_done=1 for exactly cycle 4 with the data; dc_done stays 0; REL then IDLE.
- Simultaneous requests after reset (last=I): I read 0x100 and D read 0x200 raised in the same cycle -> D granted first (owner=2, mmu_req_addr=0x200); after its done plus REL, I granted (0x100).
- Writeback lock: I pending; D write 0x300 completes -> D asserts read 0x340 during REL -> D granted again ahead of I; I granted only after the D read completes.
- D read and write both high -> mmu_req_write=1, mmu_req_read=0, mmu_write_data = dc_write_data.
- Stray mmu_done in IDLE -> no done pulse to either cache, state unchanged.
- Reset mid-grant: rst_n low while in GNT_D -> outputs 0 immediately (asynchronous), state IDLE; with TIMEOUT=8 and no mmu_done, timeout=1 after 8 granted cycles and stays set.
